piano_voice_scheduler: RTL and testbench
========================================

# piano_voice_scheduler

Tracks key make/break events from the keyboard decoder and maintains the `pressed` vector consumed by the piano-key renderer. It also allocates a fixed pool of tone-generator voices among the pressed keys. Sits between the PS/2 scancode-to-key decoder (upstream, valid/ready) and both the on-screen keyboard renderer and the tone generators (downstream, level outputs plus start pulses).

## Interface
- `OCTAVES`, 2: octaves handled; KEYS = 12*OCTAVES, key index i = note (i mod 12) of octave (i / 12), note 0 = Do.
- `VOICES`, 2: number of tone-generator voices.
- `IDX_BITS`, 5: width of a key index; must satisfy 2^IDX_BITS >= KEYS.
- `clk` in 1: system clock, all state on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `ev_valid` in 1: upstream event valid.
- `ev_ready` out 1: scheduler can accept an event.
- `ev_key` in IDX_BITS: key index of the event.
- `ev_press` in 1: 1 = make (press), 0 = break (release).
- `panic` in 1: synchronous all-notes-off.
- `pressed` out KEYS: bit i set while key i is held; renderer input.
- `voice_active` out VOICES: voice v is sounding.
- `voice_key` out VOICES*IDX_BITS: key assigned to voice v, in bits [v*IDX_BITS +: IDX_BITS]; holds its last value when inactive.
- `voice_start` out VOICES: one-cycle pulse when voice v gets a new key.
- `err_range` out 1: one-cycle pulse on an out-of-range key.

## Operation
- FSM states: IDLE, LOOKUP, UPDATE. `ev_ready` = (state == IDLE).
- IDLE: on `ev_valid && ev_ready`, latch key/press, go to LOOKUP.
- LOOKUP: register the per-voice `match` vector (active and voice_key == key) and the `free` vector (!active); register `was_pressed = pressed[key]`; go to UPDATE.
- UPDATE: apply the rules below, then go to IDLE.
- Out of range (key >= KEYS): no state change, pulse `err_range`.
- Press, was_pressed = 1: ignored.
- Press, new key: set `pressed[key]`.
  - If any voice is free, assign the lowest-index free voice.
  - Otherwise steal voice `steal_ptr`, then advance `steal_ptr` = (steal_ptr+1) mod VOICES.
  - Assigned voice: `voice_key` <= key, `voice_active` <= 1, `voice_start` pulse.
  - A stolen key stays set in `pressed` but is silent.
  - `steal_ptr` changes only on a steal.
- Release, was_pressed = 0: ignored.
- Release, held key: clear `pressed[key]` and clear `voice_active` of every matching voice. No voice is reassigned to a silent held key.
- `panic` (any state): next edge clears `pressed`, `voice_active`, `voice_start`, `err_range` and `steal_ptr`, and returns to IDLE. An in-flight event is dropped. `panic` takes priority over a simultaneous handshake, which is also dropped.
- At most one voice holds a given key at any time.

## Timing
- Reset values: state IDLE, so `ev_ready` = 1. `pressed`, `voice_active`, `voice_key`, `voice_start`, `err_range` and `steal_ptr` are all 0.
- Handshake at edge N (ev_valid & ev_ready sampled high):
  - `ev_ready` is 0 during cycles N+1 and N+2 and is 1 again from N+3.
  - `pressed`, `voice_active`, `voice_key`, `voice_start` and `err_range` all change together, visible from N+3.
  - `voice_start` and `err_range` are high for cycle N+3 only.
- Throughput: one event per 3 cycles; back-to-back events are accepted at N, N+3, N+6, ...
- The upstream must hold `ev_key` and `ev_press` stable while `ev_valid` is high and `ev_ready` is low. The scheduler latches them only at the handshake.
- All outputs are registered; no combinational path from inputs to outputs except `ev_ready` (state only).
- Reset asserted mid-event: immediate return to reset values; the event is lost.

## Test plan
- Reset, then press key 0: after handshake at N, at N+3 `pressed` = 0x000001, voice 0 active with key 0, `voice_start` = 01 for one cycle, `ev_ready` high again at N+3.
- Press 0, 4, 7 (VOICES = 2): key 7 steals voice 0 (`steal_ptr` 0→1) and pulses `voice_start[0]`. `pressed` = 0x000091, `voice_key` = {4, 7}.
- Release 0 (silent) after the previous scenario: `pressed` = 0x000090, voices unchanged. Then release 7: voice 0 inactive, `pressed` = 0x000010.
- Press 5 twice, release 9 (never pressed), press 24 (OCTAVES = 2): second press and release 9 leave all state unchanged. Key 24 pulses `err_range` and leaves `pressed` unchanged.
- Hold `ev_valid` high with four queued events: accepted at N, N+3, N+6, N+9, with `ev_ready` low for two cycles after each.
- Assert `panic` in LOOKUP of a press of key 3 with 2 voices active: next cycle all outputs cleared, state IDLE, key 3 not set.

Source files
------------

// File: rtl/piano_voice_scheduler.sv
// Piano key/voice scheduler: tracks held keys for the renderer and hands a
// small pool of tone-generator voices to newly pressed keys, stealing round-robin.
module piano_voice_scheduler #(
    parameter int OCTAVES  = 2,
    parameter int VOICES   = 2,
    parameter int IDX_BITS = 5
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         ev_valid,
    output logic                         ev_ready,
    input  logic [IDX_BITS-1:0]          ev_key,
    input  logic                         ev_press,
    input  logic                         panic,
    output logic [12*OCTAVES-1:0]        pressed,
    output logic [VOICES-1:0]            voice_active,
    output logic [VOICES*IDX_BITS-1:0]   voice_key,
    output logic [VOICES-1:0]            voice_start,
    output logic                         err_range
);

    localparam int KEYS  = 12 * OCTAVES;
    localparam int PTR_W = (VOICES > 1) ? $clog2(VOICES) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        UPDATE = 2'd2
    } state_t;

    state_t                       state_q, state_d;
    logic [IDX_BITS-1:0]          key_q, key_d;
    logic                         press_q, press_d;
    logic [VOICES-1:0]            match_q, match_d;
    logic [VOICES-1:0]            free_q, free_d;
    logic                         was_pressed_q, was_pressed_d;
    logic [KEYS-1:0]              pressed_q, pressed_d;
    logic [VOICES-1:0]            active_q, active_d;
    logic [VOICES*IDX_BITS-1:0]   vkey_q, vkey_d;
    logic [VOICES-1:0]            start_q, start_d;
    logic                         err_q, err_d;
    logic [PTR_W-1:0]             steal_q, steal_d;

    logic                         in_range_s;
    logic [KEYS-1:0]              key_mask_s;
    logic [VOICES-1:0]            match_s;
    logic                         any_free_s;
    logic [PTR_W-1:0]             free_idx_s;
    logic [PTR_W-1:0]             sel_s;

    // Decode the latched key into a range flag and a one-hot pressed mask.
    always_comb begin
        in_range_s = (int'(key_q) < KEYS);
        key_mask_s = '0;
        if (in_range_s) begin
            key_mask_s = {{(KEYS-1){1'b0}}, 1'b1} << key_q;
        end else begin
            key_mask_s = '0;
        end
    end

    // Voices currently sounding the latched key.
    always_comb begin
        match_s = '0;
        for (int v = 0; v < VOICES; v++) begin
            if (active_q[v] && (vkey_q[v*IDX_BITS +: IDX_BITS] == key_q)) begin
                match_s[v] = 1'b1;
            end else begin
                match_s[v] = 1'b0;
            end
        end
    end

    // Lowest-index free voice; falls back to the steal pointer when none is free.
    always_comb begin
        any_free_s = |free_q;
        free_idx_s = '0;
        for (int v = VOICES - 1; v >= 0; v--) begin
            if (free_q[v]) begin
                free_idx_s = PTR_W'(v);
            end else begin
                free_idx_s = free_idx_s;
            end
        end
        sel_s = any_free_s ? free_idx_s : steal_q;
    end

    // Next-state logic: event FSM plus key/voice bookkeeping.
    always_comb begin
        state_d       = state_q;
        key_d         = key_q;
        press_d       = press_q;
        match_d       = match_q;
        free_d        = free_q;
        was_pressed_d = was_pressed_q;
        pressed_d     = pressed_q;
        active_d      = active_q;
        vkey_d        = vkey_q;
        start_d       = '0;
        err_d         = 1'b0;
        steal_d       = steal_q;

        if (panic) begin
            state_d   = IDLE;
            pressed_d = '0;
            active_d  = '0;
            steal_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (ev_valid) begin
                        key_d   = ev_key;
                        press_d = ev_press;
                        state_d = LOOKUP;
                    end else begin
                        state_d = IDLE;
                    end
                end
                LOOKUP: begin
                    match_d       = match_s;
                    free_d        = ~active_q;
                    was_pressed_d = |(pressed_q & key_mask_s);
                    state_d       = UPDATE;
                end
                UPDATE: begin
                    state_d = IDLE;
                    if (!in_range_s) begin
                        err_d = 1'b1;
                    end else if (press_q && !was_pressed_q) begin
                        pressed_d = pressed_q | key_mask_s;
                        vkey_d[int'(sel_s)*IDX_BITS +: IDX_BITS] = key_q;
                        active_d[sel_s] = 1'b1;
                        start_d[sel_s]  = 1'b1;
                        if (!any_free_s) begin
                            if (steal_q == PTR_W'(VOICES - 1)) begin
                                steal_d = '0;
                            end else begin
                                steal_d = steal_q + PTR_W'(1);
                            end
                        end else begin
                            steal_d = steal_q;
                        end
                    end else if (!press_q && was_pressed_q) begin
                        pressed_d = pressed_q & ~key_mask_s;
                        active_d  = active_q & ~match_q;
                    end else begin
                        pressed_d = pressed_q;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            key_q         <= '0;
            press_q       <= 1'b0;
            match_q       <= '0;
            free_q        <= '0;
            was_pressed_q <= 1'b0;
            pressed_q     <= '0;
            active_q      <= '0;
            vkey_q        <= '0;
            start_q       <= '0;
            err_q         <= 1'b0;
            steal_q       <= '0;
        end else begin
            state_q       <= state_d;
            key_q         <= key_d;
            press_q       <= press_d;
            match_q       <= match_d;
            free_q        <= free_d;
            was_pressed_q <= was_pressed_d;
            pressed_q     <= pressed_d;
            active_q      <= active_d;
            vkey_q        <= vkey_d;
            start_q       <= start_d;
            err_q         <= err_d;
            steal_q       <= steal_d;
        end
    end

    assign ev_ready     = (state_q == IDLE);
    assign pressed      = pressed_q;
    assign voice_active = active_q;
    assign voice_key    = vkey_q;
    assign voice_start  = start_q;
    assign err_range    = err_q;

endmodule

// File: tb/tb_piano_voice_scheduler.sv
// Directed self-checking bench for piano_voice_scheduler (OCTAVES=2, VOICES=2).
module tb_piano_voice_scheduler;

    logic        clk;
    logic        rst_n;
    logic        ev_valid;
    logic        ev_ready;
    logic [4:0]  ev_key;
    logic        ev_press;
    logic        panic;
    logic [23:0] pressed;
    logic [1:0]  voice_active;
    logic [9:0]  voice_key;
    logic [1:0]  voice_start;
    logic        err_range;

    int tests  = 0;
    int failed = 0;
    int cyc    = 0;

    piano_voice_scheduler #(.OCTAVES(2), .VOICES(2), .IDX_BITS(5)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ev_valid     (ev_valid),
        .ev_ready     (ev_ready),
        .ev_key       (ev_key),
        .ev_press     (ev_press),
        .panic        (panic),
        .pressed      (pressed),
        .voice_active (voice_active),
        .voice_key    (voice_key),
        .voice_start  (voice_start),
        .err_range    (err_range)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Handshake one event; returns at the N+3 sampling point with N+1/N+2 observations.
    task automatic do_event(input logic [4:0] k, input logic p,
                            output logic r1, output logic r2, output logic [23:0] p2);
        int t;
        @(negedge clk);
        ev_valid = 1'b1; ev_key = k; ev_press = p;
        t = 0;
        while (!ev_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!ev_ready) begin
            tests++; failed++;
            $display("FAIL handshake_timeout: ev_ready got %b required 1", ev_ready);
        end
        @(posedge clk);
        @(negedge clk);
        ev_valid = 1'b0;
        r1 = ev_ready;
        @(negedge clk);
        r2 = ev_ready;
        p2 = pressed;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ev_valid = 1'b0; ev_key = 5'd0; ev_press = 1'b0; panic = 1'b0;
        #23;
        tests++; if (ev_ready !== 1'b1) begin failed++; $display("FAIL reset_ready: got %b required 1", ev_ready); end
        tests++; if (pressed !== 24'h0) begin failed++; $display("FAIL reset_pressed: got %h required 000000", pressed); end
        tests++; if (voice_active !== 2'b00) begin failed++; $display("FAIL reset_active: got %b required 00", voice_active); end
        tests++; if (voice_key !== 10'h000) begin failed++; $display("FAIL reset_vkey: got %h required 000", voice_key); end
        tests++; if (voice_start !== 2'b00 || err_range !== 1'b0) begin failed++; $display("FAIL reset_pulses: got %b/%b required 00/0", voice_start, err_range); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_press_first();
        logic r1, r2; logic [23:0] p2;
        do_event(5'd0, 1'b1, r1, r2, p2);
        tests++; if (r1 !== 1'b0 || r2 !== 1'b0) begin failed++; $display("FAIL press0_busy: got %b%b required 00", r1, r2); end
        tests++; if (p2 !== 24'h0) begin failed++; $display("FAIL press0_early: pressed at N+2 got %h required 000000", p2); end
        tests++; if (ev_ready !== 1'b1) begin failed++; $display("FAIL press0_ready: got %b required 1", ev_ready); end
        tests++; if (pressed !== 24'h000001) begin failed++; $display("FAIL press0_pressed: got %h required 000001", pressed); end
        tests++; if (voice_active !== 2'b01 || voice_key[4:0] !== 5'd0) begin failed++; $display("FAIL press0_voice: got %b/%h required 01/00", voice_active, voice_key[4:0]); end
        tests++; if (voice_start !== 2'b01) begin failed++; $display("FAIL press0_start: got %b required 01", voice_start); end
        @(negedge clk);
        tests++; if (voice_start !== 2'b00) begin failed++; $display("FAIL press0_start_end: got %b required 00", voice_start); end
    endtask

    task automatic test_steal();
        logic r1, r2; logic [23:0] p2;
        do_event(5'd4, 1'b1, r1, r2, p2);
        tests++; if (voice_start !== 2'b10 || voice_active !== 2'b11) begin failed++; $display("FAIL press4_voice: got start %b active %b required 10/11", voice_start, voice_active); end
        do_event(5'd7, 1'b1, r1, r2, p2);
        tests++; if (voice_start !== 2'b01) begin failed++; $display("FAIL steal7_start: got %b required 01", voice_start); end
        tests++; if (pressed !== 24'h000091) begin failed++; $display("FAIL steal7_pressed: got %h required 000091", pressed); end
        tests++; if (voice_key !== 10'h087) begin failed++; $display("FAIL steal7_vkey: got %h required 087", voice_key); end
    endtask

    task automatic test_release();
        logic r1, r2; logic [23:0] p2;
        do_event(5'd0, 1'b0, r1, r2, p2);
        tests++; if (pressed !== 24'h000090) begin failed++; $display("FAIL rel0_pressed: got %h required 000090", pressed); end
        tests++; if (voice_active !== 2'b11 || voice_key !== 10'h087 || voice_start !== 2'b00) begin failed++; $display("FAIL rel0_voices: got %b/%h/%b required 11/087/00", voice_active, voice_key, voice_start); end
        do_event(5'd7, 1'b0, r1, r2, p2);
        tests++; if (voice_active !== 2'b10) begin failed++; $display("FAIL rel7_active: got %b required 10", voice_active); end
        tests++; if (pressed !== 24'h000010) begin failed++; $display("FAIL rel7_pressed: got %h required 000010", pressed); end
    endtask

    task automatic test_ignored_and_range();
        logic r1, r2; logic [23:0] p2;
        do_event(5'd5, 1'b1, r1, r2, p2);
        tests++; if (pressed !== 24'h000030 || voice_key !== 10'h085 || voice_start !== 2'b01) begin failed++; $display("FAIL press5: got %h/%h/%b required 000030/085/01", pressed, voice_key, voice_start); end
        do_event(5'd5, 1'b1, r1, r2, p2);
        tests++; if (pressed !== 24'h000030 || voice_active !== 2'b11 || voice_key !== 10'h085 || voice_start !== 2'b00) begin failed++; $display("FAIL press5_again: got %h/%b/%h/%b required 000030/11/085/00", pressed, voice_active, voice_key, voice_start); end
        do_event(5'd9, 1'b0, r1, r2, p2);
        tests++; if (pressed !== 24'h000030 || voice_active !== 2'b11 || err_range !== 1'b0) begin failed++; $display("FAIL rel9_unpressed: got %h/%b/%b required 000030/11/0", pressed, voice_active, err_range); end
        do_event(5'd24, 1'b1, r1, r2, p2);
        tests++; if (err_range !== 1'b1) begin failed++; $display("FAIL range24_err: got %b required 1", err_range); end
        tests++; if (pressed !== 24'h000030 || voice_start !== 2'b00) begin failed++; $display("FAIL range24_state: got %h/%b required 000030/00", pressed, voice_start); end
        @(negedge clk);
        tests++; if (err_range !== 1'b0) begin failed++; $display("FAIL range24_err_end: got %b required 0", err_range); end
    endtask

    task automatic test_back_to_back();
        logic [4:0] keys  [4];
        logic       press [4];
        int         hs    [4];
        int         t;
        keys[0] = 5'd5;  press[0] = 1'b0;
        keys[1] = 5'd2;  press[1] = 1'b1;
        keys[2] = 5'd9;  press[2] = 1'b1;
        keys[3] = 5'd11; press[3] = 1'b1;
        @(negedge clk);
        ev_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ev_key = keys[i]; ev_press = press[i];
            t = 0;
            while (!ev_ready && t < 20) begin
                @(negedge clk);
                t++;
            end
            hs[i] = cyc;
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        ev_valid = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 1; i < 4; i++) begin
            tests++; if (hs[i] - hs[i-1] !== 3) begin failed++; $display("FAIL b2b_spacing%0d: got %0d cycles required 3", i, hs[i] - hs[i-1]); end
        end
        tests++; if (pressed !== 24'h000A14) begin failed++; $display("FAIL b2b_pressed: got %h required 000A14", pressed); end
        tests++; if (voice_key !== 10'h12B || voice_active !== 2'b11) begin failed++; $display("FAIL b2b_voices: got %h/%b required 12B/11", voice_key, voice_active); end
        tests++; if (voice_start !== 2'b01) begin failed++; $display("FAIL b2b_start: got %b required 01", voice_start); end
    endtask

    task automatic test_panic();
        logic r1, r2; logic [23:0] p2;
        @(negedge clk);
        ev_valid = 1'b1; ev_key = 5'd3; ev_press = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ev_valid = 1'b0;
        panic = 1'b1;
        @(negedge clk);
        panic = 1'b0;
        tests++; if (pressed !== 24'h0 || voice_active !== 2'b00) begin failed++; $display("FAIL panic_clear: got %h/%b required 000000/00", pressed, voice_active); end
        tests++; if (voice_start !== 2'b00 || err_range !== 1'b0 || ev_ready !== 1'b1) begin failed++; $display("FAIL panic_idle: got %b/%b/%b required 00/0/1", voice_start, err_range, ev_ready); end
        repeat (3) @(negedge clk);
        tests++; if (pressed !== 24'h0 || voice_active !== 2'b00) begin failed++; $display("FAIL panic_dropped: got %h/%b required 000000/00", pressed, voice_active); end
        do_event(5'd6, 1'b1, r1, r2, p2);
        do_event(5'd8, 1'b1, r1, r2, p2);
        do_event(5'd10, 1'b1, r1, r2, p2);
        tests++; if (voice_key !== 10'h10A || voice_start !== 2'b01) begin failed++; $display("FAIL panic_stealptr: got %h/%b required 10A/01", voice_key, voice_start); end
        tests++; if (pressed !== 24'h000540) begin failed++; $display("FAIL panic_after_pressed: got %h required 000540", pressed); end
    endtask

    initial begin
        test_reset();
        test_press_first();
        test_steal();
        test_release();
        test_ignored_and_range();
        test_back_to_back();
        test_panic();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
